serial_pixel_receiver: RTL and testbench

SERIAL_PIXEL_RECEIVER -- requirements
Module: serial_pixel_receiver

---
 rtl/serial_pixel_receiver.sv | 212 +++++++++++++++++++++
 tb/tb_serial_pixel_receiver.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pixel_receiver.sv
// serial_pixel_receiver
//
// Receives 12-bit pixel words from a serial transmitter that this block
// clocks through serck. Each frame is one start bit (0), twelve data bits
// sent MSB first, and one stop bit (1). The line idles high. Good words go
// into a two-entry FIFO that a downstream consumer drains with a
// valid/ready handshake.
//
// Parameters
//   DIV        serck half-period in clk cycles (3..255)
//
// Ports
//   clk        system clock; every flop changes on its rising edge
//   rst        synchronous active-high reset
//   enable     high: generate serck and receive
//   serck      serial bit clock driven to the transmitter
//   serdata    serial data from the transmitter (asynchronous to clk)
//   pix_data   head word of the FIFO
//   pix_valid  FIFO holds at least one unconsumed word
//   pix_ready  consumer takes the head word when pix_valid is also high
//   frame_err  one-cycle pulse when a bad stop bit is seen
//   overrun    one-cycle pulse when a good word is dropped because the FIFO is full
//   rx_count   number of words written into the FIFO (wraps)

module serial_pixel_receiver #(
   parameter int DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        serck,
   input  logic        serdata,
   output logic [11:0] pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        frame_err,
   output logic        overrun,
   output logic [15:0] rx_count
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      STOP
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

   state_t      state_q;
   state_t      state_d;
   logic [7:0]  div_cnt;
   logic        serck_q;
   logic        sync1;
   logic        sync2;
   logic        sample_pt;
   logic [3:0]  bit_cnt;
   logic [11:0] shift_reg;
   logic [11:0] fifo_mem [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  fifo_cnt;
   logic        stop_ok;
   logic        stop_bad;
   logic        push;
   logic        pop;
   logic        full;
   logic        accept;

   // Bit clock generator. serck starts low and toggles every DIV clk cycles.
   // Dropping enable parks serck low and clears the divider, so that when
   // enable comes back the first rising edge is a full half-period away.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         div_cnt <= 8'd0;
         serck_q <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= 8'd0;
         serck_q <= ~serck_q;
      end else begin
         div_cnt <= div_cnt + 8'd1;
      end
   end

   // The transmitter changes data on the serck rising edge, so the middle of
   // the bit is the edge where we pull serck back low. That is the one clk
   // edge per bit where the receiver looks at the line.
   assign sample_pt = enable && serck_q && (div_cnt == DIV_LAST);
   assign serck     = serck_q;

   // Two-flop synchronizer for the asynchronous serial line. It resets to the
   // idle level so that leaving reset can never look like a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= serdata;
         sync2 <= sync1;
      end
   end

   // Frame FSM, next-state half. It only moves at sample points. Losing
   // enable drops back to IDLE at once, and the partial word is abandoned
   // without reporting an error. STOP decides whether the assembled word is
   // kept (good stop bit) or reported as a framing error.
   always_comb begin
      state_d  = state_q;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else if (sample_pt) begin
         case (state_q)
            IDLE: begin
               if (!sync2) begin
                  state_d = DATA;
               end
            end
            DATA: begin
               if (bit_cnt == 4'd11) begin
                  state_d = STOP;
               end
            end
            STOP: begin
               state_d = IDLE;
               if (sync2) begin
                  stop_ok = 1'b1;
               end else begin
                  stop_bad = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Frame FSM, state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Bit counter and shift register. Bits come in MSB first, so each new
   // sample enters at the LSB and older bits move toward the MSB. After
   // twelve shifts the register holds the word in its natural order.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         bit_cnt   <= 4'd0;
         shift_reg <= 12'd0;
      end else if (sample_pt) begin
         case (state_q)
            IDLE: begin
               bit_cnt <= 4'd0;
            end
            DATA: begin
               shift_reg <= {shift_reg[10:0], sync2};
               bit_cnt   <= bit_cnt + 4'd1;
            end
            default: begin
               bit_cnt <= 4'd0;
            end
         endcase
      end
   end

   // Output FIFO control. A push into a full FIFO still succeeds when the
   // consumer pops in the same cycle. When full, the write pointer aims at
   // the slot being popped, so the new word lands in the slot that is just
   // being freed.
   assign push   = stop_ok;
   assign pop    = pix_valid && pix_ready;
   assign full   = (fifo_cnt == 2'd2);
   assign accept = push && (!full || pop);

   // FIFO storage, pointers, occupancy, word counter and the two event
   // pulses. The pulses are registered so they are clean single-cycle
   // strobes. Sample points are several clk cycles apart, so a pulse can
   // never stretch across two cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_mem[0] <= 12'd0;
         fifo_mem[1] <= 12'd0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
         rx_count    <= 16'd0;
         frame_err   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (accept) begin
            fifo_mem[wr_ptr] <= shift_reg;
            wr_ptr           <= ~wr_ptr;
            rx_count         <= rx_count + 16'd1;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         fifo_cnt  <= fifo_cnt + {1'b0, accept} - {1'b0, pop};
         frame_err <= stop_bad;
         overrun   <= push && full && !pop;
      end
   end

   assign pix_valid = (fifo_cnt != 2'd0);
   assign pix_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_serial_pixel_receiver.sv
// tb_serial_pixel_receiver
//
// Self-checking bench for serial_pixel_receiver with DIV = 4. A small
// transmitter model watches serck and shifts frames out on its rising edge.
// Words the receiver should keep are pushed into a scoreboard queue when
// they are sent. A monitor checks the FIFO head against that queue and pops
// the queue on every consumer handshake.

module tb_serial_pixel_receiver;

   localparam int DIV = 4;

   typedef struct {
      logic [11:0] word;
      logic        stop_bit;
      logic        exp_push;
      int          exp_fe;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        serck;
   logic        serdata;
   logic [11:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        frame_err;
   logic        overrun;
   logic [15:0] rx_count;

   int          n_vec = 0;
   int          n_err = 0;
   logic [11:0] exp_q [$];
   logic [15:0] exp_rx = 16'd0;
   int          frame_err_seen = 0;
   int          overrun_seen = 0;
   int          valid_cycles = 0;
   logic        prev_fe = 1'b0;
   logic        prev_ov = 1'b0;
   bit          tx_timeout = 1'b0;
   vec_t        vecs [6];

   serial_pixel_receiver #(.DIV(DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .serck     (serck),
      .serdata   (serdata),
      .pix_data  (pix_data),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .rx_count  (rx_count)
   );

   // Free-running 100 MHz system clock.
   always #5 clk = ~clk;

   // Hard time limit so that a stuck design cannot hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
      $fatal(1, "[TB] watchdog timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor, sampled on the falling clk edge, away from the active edge.
   // While a word is valid, the head must equal the oldest word the
   // scoreboard expects. A handshake retires that word. The monitor also
   // counts the event pulses and flags any pulse that lasts two cycles.
   always @(negedge clk) begin
      if (pix_valid === 1'b1) begin
         valid_cycles++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL unexpected_word: got 0x%0h, expected no valid word", pix_data);
         end else begin
            checkOutput("pix_data_head", 32'(pix_data), 32'(exp_q[0]));
            if (pix_ready && !rst) begin
               void'(exp_q.pop_front());
            end
         end
      end
      if (frame_err === 1'b1) begin
         frame_err_seen++;
         if (prev_fe) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL frame_err_width: got 2 consecutive cycles, expected 1");
         end
      end
      if (overrun === 1'b1) begin
         overrun_seen++;
         if (prev_ov) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL overrun_width: got 2 consecutive cycles, expected 1");
         end
      end
      prev_fe = (frame_err === 1'b1);
      prev_ov = (overrun === 1'b1);
   end

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_serck_rise();
      logic last;
      bit   seen;
      seen = 1'b0;
      last = serck;
      for (int i = 0; i < 4 * DIV + 4; i++) begin
         @(posedge clk);
         #1;
         if (serck && !last) begin
            seen = 1'b1;
            break;
         end
         last = serck;
      end
      if (!seen) begin
         tx_timeout = 1'b1;
         n_vec++;
         n_err++;
         $display("[TB] FAIL serck_rise: got no rising edge, expected one within %0d cycles", 4 * DIV + 4);
      end
   endtask

   task automatic send_bits(input logic [13:0] frame, input int nbits);
      for (int i = 13; i > 13 - nbits; i--) begin
         wait_serck_rise();
         if (tx_timeout) begin
            return;
         end
         serdata = frame[i];
      end
   endtask

   task automatic send_word(input logic [11:0] word, input logic stop_bit);
      send_bits({1'b0, word, stop_bit}, 14);
   endtask

   task automatic finish_line();
      wait_serck_rise();
      serdata = 1'b1;
   endtask

   task automatic expect_word(input logic [11:0] word);
      exp_q.push_back(word);
      exp_rx = exp_rx + 16'd1;
   endtask

   task automatic pop_one();
      pix_ready = 1'b1;
      @(posedge clk);
      #1;
      pix_ready = 1'b0;
   endtask

   // One table vector with the consumer always ready. The stop bit is
   // sampled DIV cycles after the transmitter drives it, so pix_valid must
   // still be low one cycle before that point and high right after it.
   task automatic applyStimulus(input vec_t v);
      int fe0;
      int vc0;
      fe0 = frame_err_seen;
      vc0 = valid_cycles;
      if (v.exp_push) begin
         expect_word(v.word);
      end
      send_word(v.word, v.stop_bit);
      wait_cycles(DIV - 1);
      checkOutput("valid_before_stop_sample", 32'(pix_valid), 32'd0);
      wait_cycles(1);
      checkOutput("valid_after_stop_sample", 32'(pix_valid), 32'(v.exp_push));
      finish_line();
      wait_cycles(2);
      checkOutput("frame_err_pulses", 32'(frame_err_seen - fe0), 32'(v.exp_fe));
      checkOutput("rx_count", 32'(rx_count), 32'(exp_rx));
      checkOutput("valid_cycle_count", 32'(valid_cycles - vc0), 32'(v.exp_push));
      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int ov0;
      int fe0;

      vecs[0] = '{word: 12'hA5C, stop_bit: 1'b1, exp_push: 1'b1, exp_fe: 0};
      vecs[1] = '{word: 12'h3C3, stop_bit: 1'b0, exp_push: 1'b0, exp_fe: 1};
      vecs[2] = '{word: 12'h456, stop_bit: 1'b1, exp_push: 1'b1, exp_fe: 0};
      vecs[3] = '{word: 12'h000, stop_bit: 1'b1, exp_push: 1'b1, exp_fe: 0};
      vecs[4] = '{word: 12'hFFF, stop_bit: 1'b1, exp_push: 1'b1, exp_fe: 0};
      vecs[5] = '{word: 12'h801, stop_bit: 1'b1, exp_push: 1'b1, exp_fe: 0};

      rst       = 1'b1;
      enable    = 1'b0;
      serdata   = 1'b1;
      pix_ready = 1'b0;
      wait_cycles(3);
      enable = 1'b1;
      wait_cycles(2);
      checkOutput("reset_serck", 32'(serck), 32'd0);
      checkOutput("reset_pix_valid", 32'(pix_valid), 32'd0);
      checkOutput("reset_pix_data", 32'(pix_data), 32'd0);
      checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
      checkOutput("reset_overrun", 32'(overrun), 32'd0);
      checkOutput("reset_rx_count", 32'(rx_count), 32'd0);
      rst = 1'b0;

      $display("[TB] table vectors");
      pix_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] two words held, third dropped");
      pix_ready = 1'b0;
      ov0 = overrun_seen;
      expect_word(12'h001);
      send_word(12'h001, 1'b1);
      expect_word(12'hFFF);
      send_word(12'hFFF, 1'b1);
      send_word(12'h123, 1'b1);
      finish_line();
      wait_cycles(2);
      checkOutput("overrun_pulses", 32'(overrun_seen - ov0), 32'd1);
      checkOutput("rx_count_after_overrun", 32'(rx_count), 32'(exp_rx));
      checkOutput("full_valid", 32'(pix_valid), 32'd1);
      checkOutput("full_head", 32'(pix_data), 32'h001);
      pop_one();
      checkOutput("second_head", 32'(pix_data), 32'hFFF);
      pop_one();
      checkOutput("drained_valid", 32'(pix_valid), 32'd0);

      $display("[TB] push and pop on a full buffer");
      ov0 = overrun_seen;
      expect_word(12'h2B4);
      send_word(12'h2B4, 1'b1);
      expect_word(12'h6D9);
      send_word(12'h6D9, 1'b1);
      expect_word(12'h1E7);
      send_word(12'h1E7, 1'b1);
      wait_cycles(DIV - 1);
      pix_ready = 1'b1;
      wait_cycles(1);
      pix_ready = 1'b0;
      wait_cycles(2);
      checkOutput("no_overrun_on_pop", 32'(overrun_seen - ov0), 32'd0);
      checkOutput("rx_count_push_pop", 32'(rx_count), 32'(exp_rx));
      checkOutput("head_after_push_pop", 32'(pix_data), 32'h6D9);
      pop_one();
      checkOutput("tail_after_push_pop", 32'(pix_data), 32'h1E7);
      pop_one();
      checkOutput("drained_after_push_pop", 32'(pix_valid), 32'd0);

      $display("[TB] enable dropped mid-word");
      pix_ready = 1'b1;
      fe0 = frame_err_seen;
      send_bits({1'b0, 12'h2AA, 1'b1}, 7);
      wait_cycles(2);
      enable  = 1'b0;
      serdata = 1'b1;
      wait_cycles(1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("serck_disabled", 32'(serck), 32'd0);
         wait_cycles(DIV);
      end
      enable = 1'b1;
      expect_word(12'h7E1);
      send_word(12'h7E1, 1'b1);
      finish_line();
      wait_cycles(2);
      checkOutput("no_frame_err_on_disable", 32'(frame_err_seen - fe0), 32'd0);
      checkOutput("rx_count_after_disable", 32'(rx_count), 32'(exp_rx));
      checkOutput("delivered_after_disable", 32'(exp_q.size()), 32'd0);

      $display("[TB] reset mid-word with a buffered word");
      pix_ready = 1'b0;
      expect_word(12'h5A5);
      send_word(12'h5A5, 1'b1);
      send_bits({1'b0, 12'h0F0, 1'b1}, 5);
      wait_cycles(1);
      checkOutput("buffered_before_reset", 32'(pix_valid), 32'd1);
      rst     = 1'b1;
      serdata = 1'b1;
      wait_cycles(1);
      exp_q.delete();
      exp_rx = 16'd0;
      checkOutput("rst_serck", 32'(serck), 32'd0);
      checkOutput("rst_pix_valid", 32'(pix_valid), 32'd0);
      checkOutput("rst_pix_data", 32'(pix_data), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      checkOutput("rst_rx_count", 32'(rx_count), 32'd0);
      rst       = 1'b0;
      pix_ready = 1'b1;
      expect_word(12'h9C3);
      send_word(12'h9C3, 1'b1);
      finish_line();
      wait_cycles(2);
      checkOutput("rx_count_after_reset", 32'(rx_count), 32'(exp_rx));
      checkOutput("delivered_after_reset", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
